// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_IBE  = 2'b01;
  localparam logic [1:0] EXC_ADEL = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_inst_queue.sv
// Circular instruction buffer: up to FETCH_W pushes and pops per cycle, flush empties it.
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int QDEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic [clog2(FETCH_W):0]  push_cnt_i,
  input  fetch_entry_t             push_data_i [FETCH_W],
  input  logic [clog2(FETCH_W):0]  pop_cnt_i,
  output fetch_entry_t             head_o [FETCH_W],
  output logic [clog2(QDEPTH):0]   count_o
);

  localparam int AW   = clog2(QDEPTH);
  localparam int PTRW = AW + 1;

  fetch_entry_t    mem_q [QDEPTH];
  logic [AW:0]     wr_q;
  logic [AW:0]     rd_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (!flush_i && (i < int'(push_cnt_i)))
        mem_q[wr_q[AW-1:0] + AW'(i)] <= push_data_i[i];
    end
  end

  // Flushing snaps the read pointer onto the write pointer, discarding everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      rd_q <= wr_q;
    end else begin
      wr_q <= wr_q + PTRW'(push_cnt_i);
      rd_q <= rd_q + PTRW'(pop_cnt_i);
    end
  end

  assign count_o = wr_q - rd_q;

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_head
    assign head_o[gi] = mem_q[rd_q[AW-1:0] + AW'(gi)];
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC / imem handshake FSM with drop and halt flags, feeding the instruction queue.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int          FETCH_W  = 2,
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [32*FETCH_W-1:0]    imem_rdata,
  input  logic                     imem_err,
  input  logic                     redir_valid,
  input  logic [31:0]              redir_pc,
  input  logic [clog2(FETCH_W):0]  dec_pop,
  output logic [FETCH_W-1:0]       out_valid,
  output logic [32*FETCH_W-1:0]    out_inst,
  output logic [32*FETCH_W-1:0]    out_pc,
  output logic [2*FETCH_W-1:0]     out_exc,
  output logic [clog2(QDEPTH):0]   q_count
);

  localparam int          PW       = clog2(FETCH_W) + 1;
  localparam int          CW       = clog2(QDEPTH) + 1;
  localparam logic [31:0] BLK_MASK = 32'(4 * FETCH_W - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          drop_q, drop_d;
  logic          halt_q, halt_d;

  logic          flush;
  logic          try_issue;
  logic [PW-1:0] push_cnt;
  logic [PW-1:0] pop_cnt;
  logic [CW-1:0] count_next;
  logic [31:0]   blk_base;
  logic [31:0]   lane_off;
  fetch_entry_t  push_data [FETCH_W];
  fetch_entry_t  head [FETCH_W];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    halt_d     = halt_q;
    flush      = 1'b0;
    try_issue  = 1'b0;
    push_cnt   = '0;
    pop_cnt    = dec_pop;
    count_next = '0;
    blk_base   = fetch_pc_q & ~BLK_MASK;
    lane_off   = (fetch_pc_q & BLK_MASK) >> 2;
    for (int i = 0; i < FETCH_W; i++) push_data[i] = '0;

    if (redir_valid) begin
      flush      = 1'b1;
      pop_cnt    = '0;
      fetch_pc_d = redir_pc;
      halt_d     = 1'b0;
      drop_d     = 1'b0;
      // A request already accepted by memory must have its response swallowed.
      if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else if (redir_pc[1:0] == 2'b00) begin
        state_d = S_REQ;
        addr_d  = redir_pc & ~BLK_MASK;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!halt_q) begin
            if (fetch_pc_q[1:0] != 2'b00) begin
              if (int'(q_count) != QDEPTH) begin
                push_cnt     = PW'(1);
                push_data[0] = '{pc: fetch_pc_q, inst: 32'h0, exc: EXC_ADEL};
                halt_d       = 1'b1;
              end
            end else begin
              try_issue = 1'b1;
            end
          end
        end
        S_REQ: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d   = S_IDLE;
            try_issue = 1'b1;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (imem_err) begin
              push_cnt     = PW'(1);
              push_data[0] = '{pc: fetch_pc_q, inst: 32'h0, exc: EXC_IBE};
              halt_d       = 1'b1;
            end else begin
              push_cnt = PW'(FETCH_W - int'(lane_off));
              for (int i = 0; i < FETCH_W; i++) begin
                if (i + int'(lane_off) < FETCH_W)
                  push_data[i] = '{pc:   blk_base + 32'(4 * (i + int'(lane_off))),
                                   inst: imem_rdata[(i + int'(lane_off))*32 +: 32],
                                   exc:  EXC_NONE};
              end
              fetch_pc_d = blk_base + 32'(4 * FETCH_W);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Room is judged on post-push/post-pop occupancy so a response can never overflow.
    count_next = q_count + CW'(push_cnt) - CW'(pop_cnt);
    if (try_issue && !halt_d && (fetch_pc_d[1:0] == 2'b00) &&
        ((QDEPTH - int'(count_next)) >= FETCH_W)) begin
      state_d = S_REQ;
      addr_d  = fetch_pc_d & ~BLK_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      halt_q     <= halt_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = addr_q;

  fetch_inst_queue #(
    .FETCH_W (FETCH_W),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_cnt_i  (push_cnt),
    .push_data_i (push_data),
    .pop_cnt_i   (pop_cnt),
    .head_o      (head),
    .count_o     (q_count)
  );

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_out
    assign out_valid[gi]          = int'(q_count) > gi;
    assign out_inst[gi*32 +: 32]  = head[gi].inst;
    assign out_pc[gi*32 +: 32]    = head[gi].pc;
    assign out_exc[gi*2 +: 2]     = head[gi].exc;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: scoreboarded responses, redirect vector table, corner sequences.
module tb_fetch_queue_unit;

  localparam int FW = 2;
  localparam int QD = 8;
  localparam logic [1:0] X_NONE = 2'b00;
  localparam logic [1:0] X_IBE  = 2'b01;
  localparam logic [1:0] X_ADEL = 2'b10;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [63:0]   imem_rdata;
  logic          imem_err;
  logic          redir_valid;
  logic [31:0]   redir_pc;
  logic [1:0]    dec_pop;
  logic [1:0]    out_valid;
  logic [63:0]   out_inst;
  logic [63:0]   out_pc;
  logic [3:0]    out_exc;
  logic [3:0]    q_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    int          exp_count;
    logic [1:0]  exp_valid;
  } redir_vec_t;

  exp_t        exp_q[$];
  redir_vec_t  vecs [4];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] fpc;

  fetch_queue_unit #(
    .FETCH_W  (FW),
    .QDEPTH   (QD),
    .RESET_PC (32'hbfc0_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .dec_pop     (dec_pop),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_exc     (out_exc),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_valid = 1'b1;
    redir_pc    = pc;
    exp_q.delete();
    $display("redirect to %h", pc);
    tick();
    redir_valid = 1'b0;
  endtask

  // Grants the pending request, returns its block, and scoreboards the lanes that should land.
  task automatic respond(input logic [31:0] pc, input logic err);
    logic [31:0] base;
    int          off;
    exp_t        e;
    base = pc & ~32'h7;
    off  = int'(pc[2]);
    chk("req_before_gnt", {31'b0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, base);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("req_low_in_wait", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_err    = err;
    imem_rdata  = {inst_of(base + 32'd4), inst_of(base)};
    if (err) begin
      e = '{pc: base + 32'(4 * off), inst: 32'h0, exc: X_IBE};
      exp_q.push_back(e);
    end else begin
      for (int i = off; i < FW; i++) begin
        e = '{pc: base + 32'(4 * i), inst: inst_of(base + 32'(4 * i)), exc: X_NONE};
        exp_q.push_back(e);
      end
    end
    $display("response base=%h err=%0d lanes=%0d", base, err, err ? 1 : FW - off);
    tick();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
  endtask

  // Pops from the head up to two per cycle, comparing every lane against the scoreboard.
  task automatic drain(input int max_cycles);
    int   n;
    exp_t e;
    for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
      chk("drain_count", 32'(q_count), 32'(exp_q.size()));
      n = (exp_q.size() >= FW) ? FW : exp_q.size();
      chk("drain_valid", {30'b0, out_valid}, (n == 2) ? 32'd3 : 32'd1);
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        chk("lane_pc", out_pc[i*32 +: 32], e.pc);
        chk("lane_inst", out_inst[i*32 +: 32], e.inst);
        chk("lane_exc", {30'b0, out_exc[i*2 +: 2]}, {30'b0, e.exc});
        $display("pop pc=%h inst=%h exc=%0d", e.pc, e.inst, e.exc);
      end
      dec_pop = 2'(n);
      tick();
      dec_pop = 2'd0;
    end
  endtask

  initial begin
    vecs[0] = '{target: 32'h8000_0004, exp_addr: 32'h8000_0000, exp_count: 1, exp_valid: 2'b01};
    vecs[1] = '{target: 32'h0000_1000, exp_addr: 32'h0000_1000, exp_count: 2, exp_valid: 2'b11};
    vecs[2] = '{target: 32'hffff_fff8, exp_addr: 32'hffff_fff8, exp_count: 2, exp_valid: 2'b11};
    vecs[3] = '{target: 32'h0000_300c, exp_addr: 32'h0000_3008, exp_count: 1, exp_valid: 2'b01};

    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_err    = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    dec_pop     = 2'd0;
    repeat (2) tick();
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_count", 32'(q_count), 32'd0);
    chk("reset_valid", {30'b0, out_valid}, 32'd0);

    // First fetch after reset release.
    reset = 1'b1;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    fpc = 32'hbfc0_0000;
    respond(fpc, 1'b0);
    fpc += 32'd8;
    chk("first_valid", {30'b0, out_valid}, 32'd3);
    chk("first_pc0", out_pc[31:0], 32'hbfc0_0000);
    chk("first_pc1", out_pc[63:32], 32'hbfc0_0004);
    chk("first_next_addr", imem_addr, 32'hbfc0_0008);
    drain(4);

    // Backpressure: no pops until the queue fills and requests stop.
    for (int c = 0; c < 10; c++) begin
      if (imem_req) begin
        respond(fpc, 1'b0);
        fpc += 32'd8;
      end else begin
        tick();
      end
    end
    chk("full_count", 32'(q_count), 32'd8);
    chk("full_no_req", {31'b0, imem_req}, 32'd0);
    drain(1);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, fpc);
    drain(8);

    // Redirect vector table, each retargeting a not-yet-granted request.
    for (int v = 0; v < 4; v++) begin
      redirect(vecs[v].target);
      chk("vec_req", {31'b0, imem_req}, 32'd1);
      chk("vec_addr", imem_addr, vecs[v].exp_addr);
      chk("vec_flushed", 32'(q_count), 32'd0);
      respond(vecs[v].target, 1'b0);
      chk("vec_count", 32'(q_count), 32'(vecs[v].exp_count));
      chk("vec_valid", {30'b0, out_valid}, {30'b0, vecs[v].exp_valid});
      chk("vec_next_addr", imem_addr, vecs[v].exp_addr + 32'd8);
      fpc = vecs[v].exp_addr + 32'd8;
      drain(4);
    end

    // Redirect while waiting for a response: the stale data must be dropped.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect(32'h0000_1000);
    chk("wait_redir_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = {inst_of(32'hdead_0004), inst_of(32'hdead_0000)};
    tick();
    imem_rvalid = 1'b0;
    chk("stale_count", 32'(q_count), 32'd0);
    chk("stale_req", {31'b0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0000_1000);
    fpc = 32'h0000_1000;
    respond(fpc, 1'b0);
    fpc += 32'd8;
    drain(4);

    // Redirect in the same cycle as the grant.
    imem_gnt = 1'b1;
    redirect(32'h0000_1800);
    imem_gnt = 1'b0;
    chk("gnt_redir_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = {inst_of(32'hbeef_000c), inst_of(32'hbeef_0008)};
    tick();
    imem_rvalid = 1'b0;
    chk("gnt_stale_count", 32'(q_count), 32'd0);
    chk("gnt_stale_addr", imem_addr, 32'h0000_1800);
    fpc = 32'h0000_1800;
    respond(fpc, 1'b0);
    fpc += 32'd8;
    drain(4);

    // Misaligned redirect target raises a single address-error entry.
    redirect(32'h0000_1002);
    exp_q.push_back('{pc: 32'h0000_1002, inst: 32'h0, exc: X_ADEL});
    chk("adel_noreq", {31'b0, imem_req}, 32'd0);
    tick();
    chk("adel_count", 32'(q_count), 32'd1);
    repeat (3) tick();
    chk("adel_halt_req", {31'b0, imem_req}, 32'd0);
    chk("adel_single", 32'(q_count), 32'd1);
    drain(2);
    redirect(32'h0000_2000);
    chk("adel_resume_req", {31'b0, imem_req}, 32'd1);
    chk("adel_resume_addr", imem_addr, 32'h0000_2000);
    fpc = 32'h0000_2000;
    respond(fpc, 1'b0);
    fpc += 32'd8;
    drain(4);

    // Bus error tags the entry and halts fetch.
    respond(fpc, 1'b1);
    chk("ibe_count", 32'(q_count), 32'd1);
    repeat (3) tick();
    chk("ibe_halt_req", {31'b0, imem_req}, 32'd0);
    drain(2);

    // Reset while a request is in flight; the late response must be ignored.
    redirect(32'h0000_4000);
    fpc = 32'h0000_4000;
    respond(fpc, 1'b0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_count", 32'(q_count), 32'd0);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {30'b0, out_valid}, 32'd0);
    exp_q.delete();
    tick();
    reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = {inst_of(32'h0000_400c), inst_of(32'h0000_4008)};
    tick();
    imem_rvalid = 1'b0;
    chk("late_count", 32'(q_count), 32'd0);
    chk("late_req", {31'b0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'hbfc0_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
